// File: rtl/volume_ramp.sv
// Slew-limited digital volume stage: gain steps toward the (mute-gated) target once per
// accepted sample, and the scaled sample leaves as an offset-binary DAC word two cycles later.
module volume_ramp #(
   parameter int SIG_BITS  = 16,
   parameter int VOL_BITS  = 8,
   parameter int RAMP_STEP = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SIG_BITS-1:0] in_data,
   input  logic                       in_valid,
   input  logic [VOL_BITS-1:0]        vol_target,
   input  logic                       mute,
   output logic [SIG_BITS-1:0]        out_data,
   output logic                       out_valid,
   output logic [VOL_BITS-1:0]        gain
);

   localparam logic [VOL_BITS:0]   STEP_W = (VOL_BITS+1)'(RAMP_STEP);
   localparam logic [VOL_BITS-1:0] STEP_N = VOL_BITS'(RAMP_STEP);

   logic [VOL_BITS-1:0]        target;
   logic [VOL_BITS:0]          gain_up;
   logic [VOL_BITS-1:0]        gain_q, gain_d;

   logic                       s1_valid_q;
   logic signed [SIG_BITS-1:0] s1_data_q;
   logic [VOL_BITS-1:0]        s1_gain_q;

   logic signed [SIG_BITS+VOL_BITS:0] prod;
   logic signed [SIG_BITS-1:0]        scaled;

   logic                       s2_valid_q;
   logic signed [SIG_BITS-1:0] s2_data_q;

   logic                       out_valid_q;
   logic [SIG_BITS-1:0]        out_data_q, out_data_d;

   // Ramp arithmetic is done one bit wider so the step can never wrap past the target.
   always_comb begin
      target  = mute ? '0 : vol_target;
      gain_up = {1'b0, gain_q} + STEP_W;
      gain_d  = gain_q;
      if (in_valid) begin
         if (gain_q < target) begin
            gain_d = (gain_up > {1'b0, target}) ? target : gain_up[VOL_BITS-1:0];
         end else if (gain_q > target) begin
            gain_d = ({1'b0, gain_q} < ({1'b0, target} + STEP_W)) ? target : (gain_q - STEP_N);
         end
      end
   end

   // Floor-shift of the product; the result always fits back in SIG_BITS.
   assign prod   = s1_data_q * $signed({1'b0, s1_gain_q});
   assign scaled = SIG_BITS'(prod >>> VOL_BITS);

   always_comb begin
      out_data_d = out_data_q;
      if (s2_valid_q) begin
         out_data_d = {~s2_data_q[SIG_BITS-1], s2_data_q[SIG_BITS-2:0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gain_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_gain_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= {1'b1, {(SIG_BITS-1){1'b0}}};
      end else begin
         gain_q      <= gain_d;
         s1_valid_q  <= in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         out_data_q  <= out_data_d;
         if (in_valid) begin
            s1_data_q <= in_data;
            s1_gain_q <= gain_q;
         end
         if (s1_valid_q) begin
            s2_data_q <= scaled;
         end
      end
   end

   assign gain      = gain_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_volume_ramp.sv
// Scoreboard bench for volume_ramp: two instances (step 1 and step 4) share stimulus,
// expected words are queued when a sample is driven and compared when out_valid appears.
module tb_volume_ramp;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] in_data = '0;
   logic               in_valid = 1'b0;
   logic [7:0]         vol_target = '0;
   logic               mute = 1'b0;
   logic [15:0]        out_data1, out_data4;
   logic               out_valid1, out_valid4;
   logic [7:0]         gain1, gain4;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;
   int   cyc = 0;
   int   g1_m = 0, g4_m = 0;
   logic [15:0] last1 = 16'h8000, last4 = 16'h8000;
   int   checks = 0, errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   volume_ramp #(.SIG_BITS(16), .VOL_BITS(8), .RAMP_STEP(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .vol_target(vol_target), .mute(mute),
      .out_data(out_data1), .out_valid(out_valid1), .gain(gain1));

   volume_ramp #(.SIG_BITS(16), .VOL_BITS(8), .RAMP_STEP(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .vol_target(vol_target), .mute(mute),
      .out_data(out_data4), .out_valid(out_valid4), .gain(gain4));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int next_gain(input int g, input int t, input int st);
      if (g < t) return (g + st > t) ? t : g + st;
      if (g > t) return (g - st < t) ? t : g - st;
      return g;
   endfunction

   function automatic logic [15:0] model_out(input logic signed [15:0] d, input int g);
      int p, s;
      p = int'(d) * g;
      s = p >>> 8;
      return 16'((s + 32768) & 32'hFFFF);
   endfunction

   task automatic send(input logic [15:0] d, input logic [7:0] tgt, input logic m);
      exp_t e;
      int   t;
      @(negedge clk);
      in_data    = d;
      vol_target = tgt;
      mute       = m;
      in_valid   = 1'b1;
      t      = m ? 0 : int'(tgt);
      e.cyc  = cyc + 3;
      e.data = model_out(d, g1_m);
      q1.push_back(e);
      e.data = model_out(d, g4_m);
      q4.push_back(e);
      g1_m = next_gain(g1_m, t, 1);
      g4_m = next_gain(g4_m, t, 4);
      @(posedge clk);
      #1;
      check("gain1", int'(gain1), g1_m);
      check("gain4", int'(gain4), g4_m);
      $display("sample d=%h tgt=%0d mute=%0d -> gain1=%0d gain4=%0d", d, tgt, m, gain1, gain4);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic flush_model();
      q1.delete();
      q4.delete();
      g1_m  = 0;
      g4_m  = 0;
      last1 = 16'h8000;
      last4 = 16'h8000;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid1) begin
            if (q1.size() == 0) check("spurious1", 1, 0);
            else begin
               e1 = q1.pop_front();
               check("data1", int'(out_data1), int'(e1.data));
               check("lat1", cyc, e1.cyc);
               last1 = e1.data;
            end
         end else check("hold1", int'(out_data1), int'(last1));
         if (out_valid4) begin
            if (q4.size() == 0) check("spurious4", 1, 0);
            else begin
               e4 = q4.pop_front();
               check("data4", int'(out_data4), int'(e4.data));
               check("lat4", cyc, e4.cyc);
               last4 = e4.data;
            end
         end else check("hold4", int'(out_data4), int'(last4));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(3);
      #1;
      check("rst_out", int'(out_data1), 16'h8000);
      check("rst_val", int'(out_valid1), 0);
      check("rst_gain", int'(gain1), 0);
      @(negedge clk);
      reset = 1'b0;

      // Ramp up to full scale and hold.
      for (int i = 0; i < 300; i++) begin
         send(16'h4000, 8'd255, 1'b0);
         idle(2);
      end
      check("full_gain1", int'(gain1), 255);

      // Extremes at gain 255 (full-scale negative, positive, and -1 floor).
      send(16'h8000, 8'd255, 1'b0);
      send(16'h7FFF, 8'd255, 1'b0);
      send(16'hFFFF, 8'd255, 1'b0);
      idle(4);

      // Ramp down to zero; step-4 instance clamps at 3 -> 0.
      for (int i = 0; i < 70; i++) begin
         send(16'h4000, 8'd0, 1'b0);
         idle(1);
      end
      check("zero_gain4", int'(gain4), 0);
      idle(4);

      // Back-to-back with mute rising on the 5th sample.
      for (int i = 0; i < 10; i++) begin
         send(16'($urandom), 8'd200, (i >= 4));
      end
      idle(5);

      // Randomised targets, data, mute and gaps.
      for (int i = 0; i < 60; i++) begin
         send(16'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
         idle($urandom_range(0, 2));
      end
      idle(5);

      // Asynchronous reset asserted mid-cycle.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_out", int'(out_data1), 16'h8000);
      check("arst_val", int'(out_valid1), 0);
      check("arst_gain", int'(gain1), 0);
      check("arst_gain4", int'(gain4), 0);
      flush_model();
      @(negedge clk);
      reset = 1'b0;

      // Reset pulsed one cycle after an accepted sample discards it.
      send(16'h4000, 8'd255, 1'b0);
      send(16'h4000, 8'd255, 1'b0);
      reset = 1'b1;
      flush_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("prst_gain", int'(gain1), 0);
      repeat (3) begin
         @(negedge clk);
         check("prst_noval", int'(out_valid1), 0);
      end
      send(16'h4000, 8'd255, 1'b0);
      idle(6);

      check("q1_empty", q1.size(), 0);
      check("q4_empty", q4.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
